// File: rtl/pll_nco_pkg.sv
// Shared types and constants for the pll_nco_clken NCO clock-enable generator.
// Optional per-channel tick counters are built when PLL_TICK_CNT_EN is defined.
package pll_nco_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } pll_state_t;

    localparam int TICK_CNT_W = 16;

    // Channel-index width; a single channel still needs one address bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pll_nco_ch.sv
// One NCO channel: phase accumulator, registered carry strobe, MSB square wave.
// The tick counter is built only when PLL_TICK_CNT_EN is defined.
module pll_nco_ch
    import pll_nco_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  ena,
    input  logic                  load,
    input  logic [ACC_W-1:0]      load_phase,
    input  logic [ACC_W-1:0]      inc,
    input  logic [ACC_W-1:0]      phase,
    output logic                  tick,
    output logic                  outclk,
    output logic [TICK_CNT_W-1:0] tick_cnt
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // A commit reloads the start phase; a stopped channel parks on its active
    // phase so that re-enabling resumes from a known point.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            tick   <= 1'b0;
            outclk <= 1'b0;
        end else if (load) begin
            acc    <= load_phase;
            tick   <= 1'b0;
            outclk <= 1'b0;
        end else if (run && ena) begin
            acc    <= sum[ACC_W-1:0];
            tick   <= sum[ACC_W];
            outclk <= sum[ACC_W-1];
        end else begin
            acc    <= phase;
            tick   <= 1'b0;
            outclk <= 1'b0;
        end
    end

`ifdef PLL_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_cnt = cnt;
`else
    assign tick_cnt = '0;
`endif

endmodule

// File: rtl/pll_nco_clken.sv
// NUM_CH-channel NCO clock-enable generator with shadow/commit configuration.
// Define PLL_TICK_CNT_EN to build the per-channel tick counters.
module pll_nco_clken
    import pll_nco_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic                         refclk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_commit,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [ACC_W-1:0]             cfg_inc,
    input  logic [ACC_W-1:0]             cfg_phase,
    input  logic [NUM_CH-1:0]            ena,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            outclk,
    output logic                         locked,
    output logic [TICK_CNT_W*NUM_CH-1:0] tick_cnt
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef struct packed {
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] phase;
    } ch_cfg_t;

    pll_state_t state;
    pll_state_t state_next;
    logic [SET_W-1:0] settle_cnt;
    logic             accept;
    logic             commit_acc;
    logic             write_acc;
    logic             settle_done;
    logic             run;

    ch_cfg_t shadow [NUM_CH];
    ch_cfg_t active [NUM_CH];

    // Handshake: a beat transfers on any edge where cfg_valid and cfg_ready
    // are both high; cfg_ready is low only while settling, so beats stall.
    assign cfg_ready   = (state != SETTLE);
    assign accept      = cfg_valid & cfg_ready;
    assign commit_acc  = accept & cfg_commit;
    assign write_acc   = accept & ~cfg_commit;
    assign settle_done = (state == SETTLE) && (settle_cnt == SET_W'(LOCK_CYCLES - 1));
    assign run         = (state != IDLE);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit_acc)  state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = RUN;
            RUN:     if (commit_acc)  state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else if (commit_acc) begin
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else if (settle_done) begin
            locked     <= 1'b1;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Per-channel address decode silently drops writes to absent channels.
        always_ff @(posedge refclk) begin
            if (rst) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end else begin
                if (write_acc && (cfg_ch == CH_W'(i))) begin
                    shadow[i] <= '{inc: cfg_inc, phase: cfg_phase};
                end
                if (commit_acc) begin
                    active[i] <= shadow[i];
                end
            end
        end

        pll_nco_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk        (refclk),
            .rst        (rst),
            .run        (run),
            .ena        (ena[i]),
            .load       (commit_acc),
            .load_phase (shadow[i].phase),
            .inc        (active[i].inc),
            .phase      (active[i].phase),
            .tick       (tick[i]),
            .outclk     (outclk[i]),
            .tick_cnt   (tick_cnt[TICK_CNT_W*i +: TICK_CNT_W])
        );
    end

endmodule

// File: tb/tb_pll_nco_clken.sv
// Randomised scoreboard bench for pll_nco_clken against an arithmetic NCO model.
// Tick counters are modelled when PLL_TICK_CNT_EN is defined.
module tb_pll_nco_clken;

    localparam int NUM_CH      = 2;
    localparam int ACC_W       = 24;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = 1;
    localparam int OUT_W       = 2 + 2 * NUM_CH + 16 * NUM_CH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_commit;
    logic [CH_W-1:0]        cfg_ch;
    logic [ACC_W-1:0]       cfg_inc;
    logic [ACC_W-1:0]       cfg_phase;
    logic [NUM_CH-1:0]      ena;
    logic [NUM_CH-1:0]      tick;
    logic [NUM_CH-1:0]      outclk;
    logic                   locked;
    logic [16*NUM_CH-1:0]   tick_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [OUT_W-1:0] exp_q[$];

    pll_nco_clken #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_commit (cfg_commit),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .ena        (ena),
        .tick       (tick),
        .outclk     (outclk),
        .locked     (locked),
        .tick_cnt   (tick_cnt)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each enabled channel's phase after n steps is phase + n*inc; a tick is
    // a change of the integer part of that value divided by 2^ACC_W.
    int                mode;        // 0 unconfigured, 1 settling, 2 running
    int                since;
    bit                m_locked;
    bit                m_accept;
    longint unsigned   sh_inc [NUM_CH];
    longint unsigned   sh_ph  [NUM_CH];
    longint unsigned   act_inc[NUM_CH];
    longint unsigned   act_ph [NUM_CH];
    longint unsigned   n      [NUM_CH];
    longint unsigned   v_now;
    longint unsigned   v_prev;
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_out;
    int                m_cnt  [NUM_CH];
    logic [16*NUM_CH-1:0] m_cnt_vec;

    always @(posedge clk) begin
        if (rst) begin
            mode = 0; since = 0; m_locked = 0;
            m_tick = '0; m_out = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_inc[i] = 0; sh_ph[i] = 0; act_inc[i] = 0; act_ph[i] = 0;
                n[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            m_accept = cfg_valid && (mode != 1);
            if (m_accept && cfg_commit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    act_inc[i] = sh_inc[i]; act_ph[i] = sh_ph[i];
                    n[i] = 0; m_cnt[i] = 0;
                end
                m_tick = '0; m_out = '0;
                mode = 1; since = 0; m_locked = 0;
            end else begin
                if (m_accept) begin
                    sh_inc[cfg_ch] = cfg_inc;
                    sh_ph[cfg_ch]  = cfg_phase;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_tick[i]) m_cnt[i] = (m_cnt[i] + 1) % 65536;
                    if (mode != 0 && ena[i]) begin
                        n[i]   = n[i] + 1;
                        v_now  = act_ph[i] + n[i] * act_inc[i];
                        v_prev = v_now - act_inc[i];
                        m_tick[i] = ((v_now >> ACC_W) != (v_prev >> ACC_W));
                        m_out[i]  = ((v_now >> (ACC_W - 1)) & 1) != 0;
                    end else begin
                        n[i] = 0; m_tick[i] = 1'b0; m_out[i] = 1'b0;
                    end
                end
                if (mode == 1) begin
                    since = since + 1;
                    if (since == LOCK_CYCLES) begin
                        mode = 2; m_locked = 1;
                    end
                end
            end
        end
        m_cnt_vec = '0;
`ifdef PLL_TICK_CNT_EN
        for (int i = 0; i < NUM_CH; i++) m_cnt_vec[16*i +: 16] = 16'(m_cnt[i]);
`endif
        exp_q.push_back({(mode != 1), m_locked, m_tick, m_out, m_cnt_vec});
    end

    // ---------------- monitor / scoreboard ----------------
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] want;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {cfg_ready, locked, tick, outclk, tick_cnt};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL outputs t=%0t {ready,locked,tick,outclk,tick_cnt} got=%h want=%h",
                         $time, got, want);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input bit commit, input logic [CH_W-1:0] ch,
                             input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph,
                             output int stall);
        bit done;
        done = 0;
        stall = 0;
        cfg_valid = 1'b1; cfg_commit = commit; cfg_ch = ch; cfg_inc = inc; cfg_phase = ph;
        for (int k = 0; k < 200 && !done; k++) begin
            if (cfg_ready) done = 1;
            else stall++;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout got=no accept want=accept within 200 cycles");
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [ACC_W-1:0] pick_inc();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 24'hFFFFFF;
            2:       return 24'h800000;
            default: return ACC_W'($urandom_range(0, 24'hFFFFFF));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    int stall;
    int tick1_seen;
    int anti_ok;

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0;
        cfg_ch = '0; cfg_inc = '0; cfg_phase = '0; ena = '1;
        step(3);
        rst = 1'b0;
        step(100);

        // ch0 divides by 2, ch1 by 5 (with a small fractional excess).
        send_beat(1'b0, 1'b0, 24'h800000, 24'h000000, stall);
        send_beat(1'b0, 1'b1, 24'h333334, 24'h000000, stall);
        send_beat(1'b1, 1'b0, '0, '0, stall);
        step(LOCK_CYCLES);
        tick1_seen = 0;
        for (int k = 0; k < 1000; k++) begin
            step(1);
            if (tick[1]) tick1_seen++;
        end
        check_int("tick1_count_1000", tick1_seen, 200);

        // Antiphase pair, then a write held across the settle window.
        send_beat(1'b0, 1'b0, 24'h800000, 24'h800000, stall);
        send_beat(1'b0, 1'b1, 24'h800000, 24'h000000, stall);
        send_beat(1'b1, 1'b0, '0, '0, stall);
        send_beat(1'b0, 1'b1, 24'h123456, 24'h000000, stall);
        check_int("settle_stall_cycles", stall, LOCK_CYCLES);
        anti_ok = 1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (outclk[0] == outclk[1]) anti_ok = 0;
        end
        check_int("antiphase", anti_ok, 1);
        ena = 2'b10;
        step(10);
        ena = 2'b11;
        step(20);

        // Tick-counter window (also exercises a plain re-commit).
        send_beat(1'b0, 1'b0, 24'h800000, 24'h000000, stall);
        send_beat(1'b1, 1'b0, '0, '0, stall);
        step(600);
        send_beat(1'b1, 1'b0, '0, '0, stall);
        step(30);

        // Random configuration traffic.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4:
                    send_beat(1'b0, CH_W'($urandom_range(0, NUM_CH - 1)), pick_inc(),
                              ACC_W'($urandom_range(0, 24'hFFFFFF)), stall);
                5, 6:
                    send_beat(1'b1, '0, '0, '0, stall);
                default:
                    ena = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            endcase
            step($urandom_range(1, 40));
        end

        // Reset pulse in the middle of running.
        ena = '1;
        send_beat(1'b1, '0, '0, '0, stall);
        step(40);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);
        send_beat(1'b0, 1'b0, 24'h400000, 24'h000000, stall);
        send_beat(1'b1, 1'b0, '0, '0, stall);
        step(40);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
